multi_channel_level_array: RTL
==============================

Name: multi_channel_level_array

Overview:
- Multi-channel successor to the single-channel position-to-array stage of the audio level meter.
- Accepts time-multiplexed per-channel level positions and keeps independent peak-hold state per channel, with a gradual peak fall-off once the hold time expires.
- Serially builds a width-bit LED pattern for each sample, in bar or dot mode, and hands it downstream over a valid/ready handshake.
- Sits between the level-to-position converter and the display/LED driver.

Parameters:
- width, 32, number of display segments (output array bits); any value ≥ 2.
- channels, 2, number of independent channels; any value ≥ 1.
- peak_hold_count, 1000, samples the peak marker stays fixed after being set.
- peak_decay_count, 16, samples per one-segment peak fall after the hold expires.

Ports:
- reset  input  1  asynchronous, active-high reset
- clk  input  1  clock
- i_valid  input  1  input sample valid
- i_ready  output  1  block can accept a sample (registered)
- i_channel  input  max(1,$clog2(channels))  channel index of the sample
- i_position  input  $clog2(width)  level position, 0 = lowest segment
- i_mode  input  1  0 = bar, 1 = dot; sampled on accept
- i_peak_enable  input  1  1 = draw peak marker; sampled on accept
- o_valid  output  1  output pattern valid
- o_ready  input  1  downstream accepts the pattern
- o_channel  output  max(1,$clog2(channels))  channel of the pattern
- o_array  output  width  pattern; bit k = segment k
- o_peak_position  output  $clog2(width)  peak value used for this pattern

Behaviour:
- Reset (async, any state including mid-build):
  - i_ready=1, o_valid=0, o_array=0, o_channel=0, o_peak_position=0.
  - All per-channel peak=0, hold=0, decay=0; state IDLE.
- States:
  - IDLE (i_ready=1): on i_valid && i_ready, latch channel/position/mode/peak_enable, update that channel's peak state, set i_ready=0, count=0, go to BUILD.
  - BUILD: each cycle shift the bit for segment count into the MSB of o_array (LSB-first fill); count+1. The cycle that processes count==width-1 sets o_valid=1 and goes to OUT.
  - OUT: hold o_valid, o_array, o_channel and o_peak_position stable. On o_ready, clear o_valid, set i_ready=1, go to IDLE.
- Timing:
  - o_valid rises width cycles after the accepting edge.
  - Minimum sample period is width+2 cycles.
  - i_valid is ignored whenever i_ready=0.
- Position clipping: i_position ≥ width is treated as width-1, both for drawing and for peak tracking.
- Invalid channel: i_channel ≥ channels is accepted (one-cycle i_ready drop), discarded, and produces no output; i_ready returns to 1 on the next edge.
- Peak update for the accepted channel, with p = clipped position:
  - If p ≥ peak: peak=p, hold=peak_hold_count, decay=peak_decay_count.
  - Else if hold≠0: hold−1; peak unchanged.
  - Else if decay≠0: decay−1; peak unchanged.
  - Else: peak = max(peak−1, p), decay=peak_decay_count.
  - The updated peak is the value drawn and reported on o_peak_position.
  - The peak is tracked even when i_peak_enable=0.
- Segment bit k:
  - Bar mode: (k ≤ p) OR (i_peak_enable AND k == peak).
  - Dot mode: (k == p) OR (i_peak_enable AND k == peak).
  - p=0 always lights segment 0.
- Counter widths: hold is sized $clog2(peak_hold_count+1) and decay is sized $clog2(peak_decay_count+1); neither counter wraps.

Test Plan:
Common setup: width=8, channels=3, peak_hold_count=3, peak_decay_count=2, bar mode, peak enabled unless stated.
- Decay sequence: ch0 pos 6, then ten samples of pos 1 → arrays 0x7F, then 0x43 ×5 (peak 6), then 0x23 at the 7th sample (peak 5), 0x43→0x23→0x13 pattern continuing with peak 4 at the 10th sample; o_peak_position tracks 6,6,6,6,6,6,5,5,5,4.
- Channel independence: interleave ch0 pos 6 and ch1 pos 2 → ch1 patterns 0x07 with peak 2; ch0 decay timeline identical to the previous test; o_channel matches each input.
- Mode/enable: ch2 pos 6, then ch2 pos 2 in dot mode → 0x44. Same with i_peak_enable=0 → 0x04, but o_peak_position=6.
- Backpressure and invalid channel: hold o_ready=0 for 5 cycles after o_valid → o_valid, o_array and o_channel stable, i_ready=0, i_valid pulses ignored. Sample with i_channel=3 → no o_valid, i_ready back high after 1 cycle, ch0–ch2 peak state unchanged.
- Reset mid-BUILD, 3 cycles after accept → o_valid=0, i_ready=1, o_array=0. Next ch0 pos 1 → 0x03 with peak 1, confirming the peak was cleared.

Source files
------------

// File: rtl/multi_channel_level_array.sv
// Multi-channel level-position to LED-array stage: per-channel peak hold/decay,
// serial LSB-first pattern build, valid/ready handoff to the display driver.
module multi_channel_level_array #(
    parameter int width            = 32,
    parameter int channels         = 2,
    parameter int peak_hold_count  = 1000,
    parameter int peak_decay_count = 16,
    localparam int CW = (channels > 1) ? $clog2(channels) : 1,
    localparam int PW = $clog2(width),
    localparam int HW = (peak_hold_count > 0) ? $clog2(peak_hold_count + 1) : 1,
    localparam int DW = (peak_decay_count > 0) ? $clog2(peak_decay_count + 1) : 1
) (
    input  logic             reset,
    input  logic             clk,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [CW-1:0]    i_channel,
    input  logic [PW-1:0]    i_position,
    input  logic             i_mode,
    input  logic             i_peak_enable,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [CW-1:0]    o_channel,
    output logic [width-1:0] o_array,
    output logic [PW-1:0]    o_peak_position
);

    typedef enum logic [1:0] {IDLE, BUILD, OUT, DROP} state_t;

    localparam logic [HW-1:0] HOLD_INIT  = HW'(peak_hold_count);
    localparam logic [DW-1:0] DECAY_INIT = DW'(peak_decay_count);
    localparam logic [PW-1:0] TOP_SEG    = PW'(width - 1);

    state_t state, next_state;

    logic [PW-1:0] peak_r  [channels];
    logic [HW-1:0] hold_r  [channels];
    logic [DW-1:0] decay_r [channels];

    logic [PW-1:0] cnt, pos_q;
    logic          mode_q, pen_q;

    logic          accept, chan_ok, seg_bit;
    logic [CW-1:0] ch_idx;
    logic [PW-1:0] p_clip, cur_peak, dec_peak, nxt_peak;
    logic [HW-1:0] cur_hold, nxt_hold;
    logic [DW-1:0] cur_decay, nxt_decay;

    assign accept  = i_valid && i_ready;
    assign chan_ok = int'(i_channel) < channels;
    assign ch_idx  = chan_ok ? i_channel : '0;

    // Peak tracking for the channel being offered; only committed on accept.
    always_comb begin
        p_clip    = (int'(i_position) > width - 1) ? TOP_SEG : i_position;
        cur_peak  = peak_r[ch_idx];
        cur_hold  = hold_r[ch_idx];
        cur_decay = decay_r[ch_idx];
        dec_peak  = cur_peak - PW'(1);
        nxt_peak  = cur_peak;
        nxt_hold  = cur_hold;
        nxt_decay = cur_decay;
        if (p_clip >= cur_peak) begin
            nxt_peak  = p_clip;
            nxt_hold  = HOLD_INIT;
            nxt_decay = DECAY_INIT;
        end else if (cur_hold != '0) begin
            nxt_hold = cur_hold - HW'(1);
        end else if (cur_decay != '0) begin
            nxt_decay = cur_decay - DW'(1);
        end else begin
            nxt_peak  = (dec_peak > p_clip) ? dec_peak : p_clip;
            nxt_decay = DECAY_INIT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < channels; c++) begin
                peak_r[c]  <= '0;
                hold_r[c]  <= '0;
                decay_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < channels; c++) begin
                if (accept && chan_ok && ch_idx == CW'(c)) begin
                    peak_r[c]  <= nxt_peak;
                    hold_r[c]  <= nxt_hold;
                    decay_r[c] <= nxt_decay;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = chan_ok ? BUILD : DROP;
            BUILD:   if (cnt == TOP_SEG) next_state = OUT;
            OUT:     if (o_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        i_ready = (state == IDLE);
        o_valid = (state == OUT);
    end

    // o_peak_position doubles as the latched peak used while drawing.
    assign seg_bit = (mode_q ? (cnt == pos_q) : (cnt <= pos_q))
                   || (pen_q && cnt == o_peak_position);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt             <= '0;
            pos_q           <= '0;
            mode_q          <= 1'b0;
            pen_q           <= 1'b0;
            o_array         <= '0;
            o_channel       <= '0;
            o_peak_position <= '0;
        end else begin
            case (state)
                IDLE: if (accept && chan_ok) begin
                    cnt             <= '0;
                    pos_q           <= p_clip;
                    mode_q          <= i_mode;
                    pen_q           <= i_peak_enable;
                    o_channel       <= i_channel;
                    o_peak_position <= nxt_peak;
                end
                BUILD: begin
                    o_array <= {seg_bit, o_array[width-1:1]};
                    cnt     <= cnt + PW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
